// File: rtl/mul4_pkg.sv
// Shared definitions for the sequential 4x4 shift-and-add multiplier controller:
// FSM state encoding, ALU control encodings and the operand-B select helper.
package mul4_pkg;

    localparam int OP_W = 4;
    localparam int ITER = 4;

    // Last iteration index; the counter stops here instead of wrapping.
    localparam logic [1:0] CNT_LAST = 2'(ITER - 1);

    localparam logic [1:0] ALUOP_ADD = 2'b10;
    localparam logic [1:0] ALUOP_NOP = 2'b00;
    localparam logic       L_ARITH   = 1'b0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ADD   = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Partial-product operand: the multiplicand when the current multiplier bit is set.
    function automatic logic [OP_W-1:0] alu_b_sel(input logic lsb, input logic [OP_W-1:0] x);
        logic [OP_W-1:0] res;
        if (lsb) begin
            res = x;
        end else begin
            res = {OP_W{1'b0}};
        end
        return res;
    endfunction

endpackage

// File: rtl/mul4_seq_ctrl.sv
// Sequential unsigned 4x4->8 multiplier that borrows an external 4-bit ALU as
// its adder. {C,HI,LO} form a 9-bit accumulator/multiplier register pair that
// is added into (HI) and shifted right once per multiplier bit.
// All outputs, including the ALU controls, are registered: the ALU controls are
// computed from the next state so they are valid throughout each ADD cycle.
module mul4_seq_ctrl
    import mul4_pkg::*;
#(
    parameter int N_BITS = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [N_BITS-1:0]   op_x,
    input  logic [N_BITS-1:0]   op_y,
    output logic                busy,
    output logic                done,
    output logic [2*N_BITS-1:0] product,
    output logic [N_BITS-1:0]   alu_a,
    output logic [N_BITS-1:0]   alu_b,
    output logic [1:0]          alu_op,
    output logic                alu_l,
    output logic                alu_cin,
    input  logic [N_BITS-1:0]   alu_r,
    input  logic                alu_cout
);

    state_t              state_q, state_d;
    logic [N_BITS-1:0]   x_q, x_d;
    logic [N_BITS-1:0]   hi_q, hi_d;
    logic [N_BITS-1:0]   lo_q, lo_d;
    logic                c_q, c_d;
    logic [1:0]          cnt_q, cnt_d;
    logic [2*N_BITS-1:0] product_q, product_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [N_BITS-1:0]   alu_a_q, alu_a_d;
    logic [N_BITS-1:0]   alu_b_q, alu_b_d;
    logic [1:0]          alu_op_q, alu_op_d;
    logic                alu_l_q, alu_l_d;
    logic                alu_cin_q, alu_cin_d;

    // Next-state, datapath update and registered-output precomputation.
    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        c_d       = c_q;
        cnt_d     = cnt_q;
        product_d = product_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ADD;
                    x_d     = op_x;
                    hi_d    = {N_BITS{1'b0}};
                    lo_d    = op_y;
                    c_d     = 1'b0;
                    cnt_d   = 2'd0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ADD: begin
                // Carry out is kept in C so the 5-bit partial sum is preserved.
                hi_d    = alu_r;
                c_d     = alu_cout;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                {c_d, hi_d, lo_d} = {1'b0, c_q, hi_q, lo_q[N_BITS-1:1]};
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = cnt_q;
                    state_d = S_DONE;
                end else begin
                    cnt_d   = cnt_q + 2'd1;
                    state_d = S_ADD;
                end
            end
            S_DONE: begin
                product_d = {hi_q, lo_q};
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // ALU controls for the upcoming cycle: only an ADD cycle uses the ALU.
        alu_l_d   = L_ARITH;
        alu_cin_d = 1'b0;
        if (state_d == S_ADD) begin
            alu_a_d  = hi_d;
            alu_b_d  = alu_b_sel(lo_d[0], x_d);
            alu_op_d = ALUOP_ADD;
        end else begin
            alu_a_d  = {N_BITS{1'b0}};
            alu_b_d  = {N_BITS{1'b0}};
            alu_op_d = ALUOP_NOP;
        end

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // State, datapath and output registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            x_q       <= {N_BITS{1'b0}};
            hi_q      <= {N_BITS{1'b0}};
            lo_q      <= {N_BITS{1'b0}};
            c_q       <= 1'b0;
            cnt_q     <= 2'd0;
            product_q <= {(2*N_BITS){1'b0}};
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            alu_a_q   <= {N_BITS{1'b0}};
            alu_b_q   <= {N_BITS{1'b0}};
            alu_op_q  <= ALUOP_NOP;
            alu_l_q   <= L_ARITH;
            alu_cin_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            c_q       <= c_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_op_q  <= alu_op_d;
            alu_l_q   <= alu_l_d;
            alu_cin_q <= alu_cin_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;
    assign alu_a   = alu_a_q;
    assign alu_b   = alu_b_q;
    assign alu_op  = alu_op_q;
    assign alu_l   = alu_l_q;
    assign alu_cin = alu_cin_q;

endmodule

// File: tb/tb_mul4_seq_ctrl.sv
// Directed bench for mul4_seq_ctrl with a behavioural 4-bit ALU on the alu_* ports.
module tb_mul4_seq_ctrl;

    logic       clk;
    logic       reset;
    logic       start;
    logic [3:0] op_x;
    logic [3:0] op_y;
    logic       busy;
    logic       done;
    logic [7:0] product;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [1:0] alu_op;
    logic       alu_l;
    logic       alu_cin;
    logic [3:0] alu_r;
    logic       alu_cout;
    logic [4:0] alu_res;

    int n_checks;
    int n_errors;

    mul4_seq_ctrl #(.N_BITS(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op_x     (op_x),
        .op_y     (op_y),
        .busy     (busy),
        .done     (done),
        .product  (product),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_op   (alu_op),
        .alu_l    (alu_l),
        .alu_cin  (alu_cin),
        .alu_r    (alu_r),
        .alu_cout (alu_cout)
    );

    // Behavioural ALU: arithmetic add for op 2'b10, AND in logic mode, else pass A.
    always_comb begin
        if (alu_l == 1'b1) begin
            alu_res = {1'b0, alu_a & alu_b};
        end else if (alu_op == 2'b10) begin
            alu_res = {1'b0, alu_a} + {1'b0, alu_b} + {4'b0000, alu_cin};
        end else begin
            alu_res = {1'b0, alu_a};
        end
    end
    assign alu_r    = alu_res[3:0];
    assign alu_cout = alu_res[4];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Runs one multiply starting from an IDLE negedge; reports result, latency and ALU activity.
    // add_m[k]/nop_m[k]: ALU controls at negedge k after acceptance are ADD / all-zero.
    task automatic run_mul(input logic [3:0] x, input logic [3:0] y,
                           output logic [7:0] prod, output int lat,
                           output bit saw_cout, output bit saw_bnz,
                           output logic [9:0] add_m, output logic [9:0] nop_m);
        saw_cout = 1'b0;
        saw_bnz  = 1'b0;
        add_m    = 10'd0;
        nop_m    = 10'd0;
        lat      = -1;
        op_x  = x;
        op_y  = y;
        start = 1'b1;
        add_m[0] = (alu_op == 2'b10) && !alu_l && !alu_cin;
        nop_m[0] = (alu_op == 2'b00) && !alu_l && !alu_cin && (alu_a == 4'd0) && (alu_b == 4'd0);
        @(posedge clk);
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k <= 9) begin
                add_m[k] = (alu_op == 2'b10) && !alu_l && !alu_cin;
                nop_m[k] = (alu_op == 2'b00) && !alu_l && !alu_cin && (alu_a == 4'd0) && (alu_b == 4'd0);
            end
            if (alu_op == 2'b10) begin
                if (alu_cout) saw_cout = 1'b1;
                if (alu_b != 4'd0) saw_bnz = 1'b1;
            end
            if (done) begin
                lat = k;
                break;
            end
        end
        @(negedge clk);
        prod = product;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        op_x  = 4'd0;
        op_y  = 4'd0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy, done, product} !== 10'd0) begin
            n_errors++;
            $display("FAIL reset_outputs: busy=%b done=%b product=%0d, expected 0/0/0", busy, done, product);
        end
        n_checks++;
        if ({alu_a, alu_b, alu_op, alu_l, alu_cin} !== 12'd0) begin
            n_errors++;
            $display("FAIL reset_alu: a=%0d b=%0d op=%b l=%b cin=%b, expected all 0", alu_a, alu_b, alu_op, alu_l, alu_cin);
        end
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_errors++;
            $display("FAIL idle_busy: busy=%b, expected 0", busy);
        end
    endtask

    task automatic test_basic();
        logic [7:0] p; int lat; bit sc, sb; logic [9:0] am, nm;
        run_mul(4'd3, 4'd5, p, lat, sc, sb, am, nm);
        n_checks++;
        if (p !== 8'd15) begin
            n_errors++;
            $display("FAIL basic_product: got %0d, expected 15", p);
        end
        n_checks++;
        if (lat != 9) begin
            n_errors++;
            $display("FAIL basic_latency: done after %0d cycles, expected 9", lat);
        end
        n_checks++;
        if (am !== 10'h0AA || nm !== 10'h355) begin
            n_errors++;
            $display("FAIL basic_alu_ctrl: add_mask=%h nop_mask=%h, expected 0aa/355", am, nm);
        end
    endtask

    task automatic test_carry();
        logic [7:0] p; int lat; bit sc, sb; logic [9:0] am, nm;
        run_mul(4'd15, 4'd15, p, lat, sc, sb, am, nm);
        n_checks++;
        if (p !== 8'd225) begin
            n_errors++;
            $display("FAIL carry_product: got %0d, expected 225", p);
        end
        n_checks++;
        if (sc !== 1'b1) begin
            n_errors++;
            $display("FAIL carry_cout_seen: saw_cout=%b, expected 1", sc);
        end
    endtask

    task automatic test_zero();
        logic [7:0] p; int lat; bit sc, sb; logic [9:0] am, nm;
        run_mul(4'd0, 4'd9, p, lat, sc, sb, am, nm);
        n_checks++;
        if (p !== 8'd0) begin
            n_errors++;
            $display("FAIL zero_x_product: got %0d, expected 0", p);
        end
        run_mul(4'd9, 4'd0, p, lat, sc, sb, am, nm);
        n_checks++;
        if (p !== 8'd0) begin
            n_errors++;
            $display("FAIL zero_y_product: got %0d, expected 0", p);
        end
        n_checks++;
        if (sb !== 1'b0) begin
            n_errors++;
            $display("FAIL zero_y_alu_b: nonzero alu_b seen=%b, expected 0", sb);
        end
    endtask

    // start held high through an operation while operands change; second op must use late operands.
    task automatic test_back_to_back();
        int n_done;
        logic [7:0] p_first;
        logic busy_gap, busy_second;
        n_done      = 0;
        p_first     = 8'hxx;
        busy_gap    = 1'bx;
        busy_second = 1'bx;
        op_x  = 4'd2;
        op_y  = 4'd3;
        start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 2) begin
                op_x = 4'd5;
                op_y = 4'd9;
            end
            if (k == 10) begin
                p_first  = product;
                busy_gap = busy;
            end
            if (k == 11) busy_second = busy;
            if (k == 15) start = 1'b0;
            if (done) n_done++;
        end
        n_checks++;
        if (p_first !== 8'd6) begin
            n_errors++;
            $display("FAIL lockout_first_product: got %0d, expected 6", p_first);
        end
        n_checks++;
        if (busy_gap !== 1'b0 || busy_second !== 1'b1) begin
            n_errors++;
            $display("FAIL lockout_restart: busy at idle gap=%b next=%b, expected 0/1", busy_gap, busy_second);
        end
        n_checks++;
        if (n_done != 2) begin
            n_errors++;
            $display("FAIL lockout_done_count: %0d pulses, expected 2", n_done);
        end
        n_checks++;
        if (product !== 8'd45) begin
            n_errors++;
            $display("FAIL lockout_second_product: got %0d, expected 45", product);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] p; int lat; bit sc, sb; logic [9:0] am, nm;
        op_x  = 4'd13;
        op_y  = 4'd11;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) begin
            n_errors++;
            $display("FAIL rstmid_busy_before: busy=%b, expected 1", busy);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== 8'd0) begin
            n_errors++;
            $display("FAIL rstmid_abort: busy=%b done=%b product=%0d, expected 0/0/0", busy, done, product);
        end
        @(negedge clk);
        reset = 1'b0;
        run_mul(4'd3, 4'd4, p, lat, sc, sb, am, nm);
        n_checks++;
        if (p !== 8'd12 || lat != 9) begin
            n_errors++;
            $display("FAIL rstmid_restart: product=%0d latency=%0d, expected 12/9", p, lat);
        end
    endtask

    task automatic test_sweep();
        logic [7:0] p; int lat; bit sc, sb; logic [9:0] am, nm;
        logic [7:0] exp_p;
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                run_mul(4'(i), 4'(j), p, lat, sc, sb, am, nm);
                exp_p = 8'(i * j);
                n_checks++;
                if (p !== exp_p || lat != 9) begin
                    n_errors++;
                    $display("FAIL sweep_product %0dx%0d: got %0d lat %0d, expected %0d lat 9", i, j, p, lat, exp_p);
                end
                n_checks++;
                if (am !== 10'h0AA || nm !== 10'h355) begin
                    n_errors++;
                    $display("FAIL sweep_alu_ctrl %0dx%0d: add_mask=%h nop_mask=%h, expected 0aa/355", i, j, am, nm);
                end
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_basic();
        test_carry();
        test_zero();
        test_back_to_back();
        test_reset_mid();
        @(negedge clk);
        test_sweep();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
